// File: rtl/regs_pkg.sv
// Shared defaults and state type for the picoMIPS multi-port register file.
package regs_pkg;
  localparam int REG_WIDTH = 8;
  localparam int REG_DEPTH = 8;
  localparam int REG_UNITY = 1 << 3;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} regs_state_t;
endpackage

// File: rtl/regs_init_seq.sv
// Post-reset initialisation sequencer: walks every entry once, then reports ready.
module regs_init_seq
  import regs_pkg::*;
#(
  parameter int DEPTH  = REG_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_ready
);

  regs_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_init_we   = (r_state == INIT);
  assign o_init_addr = r_cnt;
  assign o_ready     = r_ready;

endmodule

// File: rtl/regs_file_mp.sv
// Multi-port register file: one write port, two registered read ports, self-initialising.
// Define REGS_BYPASS_EN for write-first read-during-write; default is read-first.
module regs_file_mp
  import regs_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = REG_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int INIT_VAL = REG_UNITY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  qa,
  output logic [WIDTH-1:0]  qb,
  output logic              ready
);

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_ready;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WIDTH-1:0]  w_mem_d;
  logic [WIDTH-1:0]  w_qa_nxt;
  logic [WIDTH-1:0]  w_qb_nxt;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_qa_p1;
  logic [WIDTH-1:0]  r_qb_p1;

  regs_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .i_clk       (clk),
    .i_rst       (reset),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_ready     (w_ready)
  );

  // The sequencer owns the write port until ready; user writes are dropped before then.
  assign w_mem_we   = w_init_we | (w_ready & we);
  assign w_mem_addr = w_init_we ? w_init_addr : wr_addr;
  assign w_mem_d    = w_init_we ? WIDTH'(INIT_VAL) : d;

  // Stage p0 -> memory: no reset on the array, the sequencer overwrites it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_d;
  end

  always_comb begin
    w_qa_nxt = r_mem[rd_addr_a];
    w_qb_nxt = r_mem[rd_addr_b];
`ifdef REGS_BYPASS_EN
    if (we && (wr_addr == rd_addr_a)) w_qa_nxt = d;
    if (we && (wr_addr == rd_addr_b)) w_qb_nxt = d;
`endif
  end

  // Stage p1: registered read data, forced to zero until initialisation completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_qa_p1 <= '0;
      r_qb_p1 <= '0;
    end else if (!w_ready) begin
      r_qa_p1 <= '0;
      r_qb_p1 <= '0;
    end else begin
      r_qa_p1 <= w_qa_nxt;
      r_qb_p1 <= w_qb_nxt;
    end
  end

  assign qa    = r_qa_p1;
  assign qb    = r_qb_p1;
  assign ready = w_ready;

endmodule

// File: doc/regs_file_mp.md
# regs_file_mp

Parametrised multi-port register file for the picoMIPS datapath, succeeding the single-read-port register memory. It provides one synchronous write port and two synchronous read ports. A built-in initialisation sequencer loads every entry with the fixed-point unity value after reset, so initialisation no longer relies on simulation-only `initial` blocks. Optional write-to-read bypass is compiled in or out.

## Interface
- `WIDTH`, 8, data width in bits.
- `DEPTH`, 8, number of registers; must be a power of two and at least 2.
- `ADDR_W`, `$clog2(DEPTH)`, address width; derived, never overridden.
- `INIT_VAL`, `8` (`1 << 3`), value loaded into every entry by the sequencer. It is fixed-point unity, because immediates carry 3 fractional bits.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `we`  in  1  write enable; honoured only when `ready`=1.
- `wr_addr`  in  `ADDR_W`  write address.
- `d`  in  `WIDTH`  write data.
- `rd_addr_a`, `rd_addr_b`  in  `ADDR_W`  read addresses for ports A and B.
- `qa`, `qb`  out  `WIDTH`  registered read data.
- `ready`  out  1  high once initialisation is complete.

## Operation
- FSM states: `INIT`, `RUN`. Reset forces `INIT` with the init counter at 0.
- `INIT` state:
  - Each cycle, write `INIT_VAL` to entry `cnt`, then increment `cnt`.
  - When `cnt`=`DEPTH-1` is written, go to `RUN`.
  - `we` is ignored.
  - `qa`/`qb` are held at 0.
- `RUN` state:
  - If `we`=1, `mem[wr_addr]` takes `d` at the clock edge.
  - Each cycle, `qa` takes `mem[rd_addr_a]` and `qb` takes `mem[rd_addr_b]`.
  - The FSM stays in `RUN` until reset.
- Both read ports may use the same address; both return identical data.
- There are no writes from reads, and no special-casing of entry 0: zeroing is done in software.
- Read-during-write to the same address is governed by the `REGS_BYPASS_EN` macro (see Configuration).
- Reset asserted mid-`INIT` or mid-`RUN`:
  - `qa`, `qb` and `ready` clear immediately.
  - The FSM returns to `INIT` and `cnt` returns to 0.
  - Memory contents are not cleared asynchronously; the re-run sequence overwrites them.

## Timing
- Reset values: `qa`=0, `qb`=0, `ready`=0, state=`INIT`, `cnt`=0.
- Initialisation takes exactly `DEPTH` cycles. Entry 0 is written on the first rising edge after `reset` deasserts.
- `ready` is registered. It rises on the same edge that writes entry `DEPTH-1`, which is edge number `DEPTH` after release.
- Read latency is 1 cycle: an address presented before edge N appears on `qa`/`qb` after edge N.
- Write latency is 1 cycle: data written at edge N is readable via address presented before edge N+1, and appears after edge N+1.
- A `we` pulse on the same edge that `ready` rises is ignored, because that edge is still `INIT`.

## Configuration
- `REGS_BYPASS_EN` defined:
  - When `we`=1 and `wr_addr` equals a port's read address in `RUN`, that port outputs `d` on the same edge (write-first).
  - The comparison is made independently per port.
- `REGS_BYPASS_EN` undefined:
  - The same case returns the old contents (read-first).
  - The new value is visible one cycle later.
  - This allows pure block-RAM inference.

## Structure
- Shared package `regs_pkg`: `REG_WIDTH`, `REG_DEPTH` and `REG_UNITY` (=`1<<3`) defaults, plus the state enum `regs_state_t {INIT, RUN}`.
- `regs_file_mp` instantiates one sub-module, `regs_init_seq`. It holds the FSM and the init counter, and drives the internal write mux signals (`init_we`, `init_addr`) plus `ready`.
- The memory array and read registers live in `regs_file_mp`.

## Test plan
All scenarios use `WIDTH`=8, `DEPTH`=8.
- Reset pulse, then 8 idle cycles → `ready` 0 for edges 1–7 and 1 after edge 8; reading every address then gives `qa`=`qb`=8.
- Once `ready`=1, write 0x3C to addr 5, then read addr 5 on A and addr 2 on B next cycle → `qa`=0x3C, `qb`=0x08 one cycle later.
- Assert `we` with `d`=0x77 at addr 1 during `INIT` (cycle 3) → after `ready`, addr 1 reads 0x08.
- Write 0x55 to addr 4 while `rd_addr_a`=4 → with `REGS_BYPASS_EN`, `qa`=0x55 after that edge; without it, `qa`=0x08 then 0x55 next cycle.
- Assert `reset` at init cycle 4 for 1 cycle → `ready` drops immediately, full 8-cycle sequence restarts, and all entries read 8.
- Write 0xA0 to addr 7, then assert `reset` mid-`RUN` → `qa`/`qb`=0 immediately; after re-init, addr 7 reads 0x08.
